// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   - result-source select codes (wb_sel)
//   - load-size codes (ld_size)
//   - writeback FSM state encoding
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [1:0] LD_WORD = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_BYTE = 2'd2;

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_ext_load_extract.sv
// load_extract: combinational sub-word lane select and sign/zero extension.
// Ports:
//   data      in   DATA_W     raw memory read data
//   addr_lo   in   ADDR_LO_W  low address bits selecting the lane
//   size      in   2          LD_WORD / LD_HALF / LD_BYTE (3 treated as word)
//   signed_ld in   1          1 = sign-extend, 0 = zero-extend
//   out       out  DATA_W     extracted, extended value
module load_extract
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_LO_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0]    data,
    input  logic [ADDR_LO_W-1:0] addr_lo,
    input  logic [1:0]           size,
    input  logic                 signed_ld,
    output logic [DATA_W-1:0]    out
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int NUM_HALVES = DATA_W / 16;

    logic [7:0]  byte_lane [NUM_BYTES];
    logic [15:0] half_lane [NUM_HALVES];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_lane
            assign byte_lane[gi] = data[gi*8 +: 8];
        end
        for (gi = 0; gi < NUM_HALVES; gi++) begin : g_half_lane
            assign half_lane[gi] = data[gi*16 +: 16];
        end
    endgenerate

    // Half-word lane ignores addr_lo[0]: misaligned halves are silently aligned down.
    assign byte_sel = byte_lane[addr_lo];
    assign half_sel = half_lane[addr_lo[ADDR_LO_W-1:1]];

    always_comb begin
        out = data;
        case (size)
            LD_HALF: out = {{(DATA_W-16){signed_ld & half_sel[15]}}, half_sel};
            LD_BYTE: out = {{(DATA_W-8){signed_ld & byte_sel[7]}}, byte_sel};
            default: out = data;
        endcase
    end

endmodule

// File: rtl/wb_stage_ext.sv
// wb_stage_ext: writeback stage between MEM and the register file.
// Selects the result source (ALU / MEM / LINK), extracts sub-word loads, and
// waits for late memory responses with a timeout. Produces one registered
// register-file write per instruction plus hazard info about a waiting load.
// Ports:
//   clk, rst (async, active low)
//   flush                          discard held and incoming instruction
//   in_valid / in_ready            handshake with the MEM stage
//   WB_EN_In, Dest_In, wb_sel,
//   ld_size, ld_signed, ALU_Res,
//   Link_Val                       instruction control and operands
//   mem_rsp_valid, Mem_Data        memory response
//   WB_EN_Out, Dest_Out, WB_Value  registered register-file write
//   pend_valid, pend_dest          load waiting in WAIT_MEM
//   mem_timeout                    sticky flag: a load was squashed on timeout
module wb_stage_ext
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_EN_In,
    input  logic [REG_W-1:0]  Dest_In,
    input  logic [1:0]        wb_sel,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] ALU_Res,
    input  logic [DATA_W-1:0] Link_Val,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic              WB_EN_Out,
    output logic [REG_W-1:0]  Dest_Out,
    output logic [DATA_W-1:0] WB_Value,
    output logic              pend_valid,
    output logic [REG_W-1:0]  pend_dest,
    output logic              mem_timeout
);

    localparam int ADDR_LO_W = $clog2(DATA_W / 8);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    wb_state_t state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next, wait_cnt_inc;

    // Control of the load parked in WAIT_MEM.
    logic                 lat_wb_en_reg, lat_wb_en_next;
    logic [REG_W-1:0]     lat_dest_reg, lat_dest_next;
    logic [1:0]           lat_size_reg, lat_size_next;
    logic                 lat_signed_reg, lat_signed_next;
    logic [ADDR_LO_W-1:0] lat_addr_reg, lat_addr_next;

    logic                 mem_timeout_reg, mem_timeout_next;
    logic                 wb_en_out_reg, wb_en_out_next;
    logic [REG_W-1:0]     dest_out_reg, dest_out_next;
    logic [DATA_W-1:0]    wb_value_reg, wb_value_next;

    logic                 accept;
    logic                 waiting;
    logic [1:0]           ext_size;
    logic                 ext_signed;
    logic [ADDR_LO_W-1:0] ext_addr;
    logic [DATA_W-1:0]    ext_data;
    logic [DATA_W-1:0]    pass_value;

    assign waiting  = (state_reg == ST_WAIT_MEM);
    assign in_ready = !waiting;
    assign accept   = in_valid && in_ready;

    assign wait_cnt_inc = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;

    // A single extractor serves both the same-cycle load and the late response:
    // while waiting, lane/size come from the parked control, data is always live.
    assign ext_size   = waiting ? lat_size_reg   : ld_size;
    assign ext_signed = waiting ? lat_signed_reg : ld_signed;
    assign ext_addr   = waiting ? lat_addr_reg   : ALU_Res[ADDR_LO_W-1:0];

    load_extract #(
        .DATA_W    (DATA_W),
        .ADDR_LO_W (ADDR_LO_W)
    ) u_load_extract (
        .data      (Mem_Data),
        .addr_lo   (ext_addr),
        .size      (ext_size),
        .signed_ld (ext_signed),
        .out       (ext_data)
    );

    // Reserved wb_sel = 3 falls through to ALU.
    assign pass_value = (wb_sel == WB_SEL_LINK) ? Link_Val : ALU_Res;

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        lat_wb_en_next   = lat_wb_en_reg;
        lat_dest_next    = lat_dest_reg;
        lat_size_next    = lat_size_reg;
        lat_signed_next  = lat_signed_reg;
        lat_addr_next    = lat_addr_reg;
        mem_timeout_next = mem_timeout_reg;
        wb_en_out_next   = 1'b0;
        dest_out_next    = dest_out_reg;
        wb_value_next    = wb_value_reg;

        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        if (wb_sel == WB_SEL_MEM && !mem_rsp_valid) begin
                            state_next      = ST_WAIT_MEM;
                            wait_cnt_next   = 8'd0;
                            lat_wb_en_next  = WB_EN_In;
                            lat_dest_next   = Dest_In;
                            lat_size_next   = ld_size;
                            lat_signed_next = ld_signed;
                            lat_addr_next   = ALU_Res[ADDR_LO_W-1:0];
                        end else begin
                            wb_en_out_next = WB_EN_In;
                            dest_out_next  = Dest_In;
                            wb_value_next  = (wb_sel == WB_SEL_MEM) ? ext_data : pass_value;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rsp_valid) begin
                        state_next     = ST_EMPTY;
                        wb_en_out_next = lat_wb_en_reg;
                        dest_out_next  = lat_dest_reg;
                        wb_value_next  = ext_data;
                    end else begin
                        wait_cnt_next = wait_cnt_inc;
                        // Squash: strobe stays low, write data/address hold.
                        if (wait_cnt_inc == TIMEOUT_CNT) begin
                            state_next       = ST_EMPTY;
                            mem_timeout_next = 1'b1;
                        end
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_EMPTY;
            wait_cnt_reg    <= 8'd0;
            lat_wb_en_reg   <= 1'b0;
            lat_dest_reg    <= '0;
            lat_size_reg    <= LD_WORD;
            lat_signed_reg  <= 1'b0;
            lat_addr_reg    <= '0;
            mem_timeout_reg <= 1'b0;
            wb_en_out_reg   <= 1'b0;
            dest_out_reg    <= '0;
            wb_value_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            lat_wb_en_reg   <= lat_wb_en_next;
            lat_dest_reg    <= lat_dest_next;
            lat_size_reg    <= lat_size_next;
            lat_signed_reg  <= lat_signed_next;
            lat_addr_reg    <= lat_addr_next;
            mem_timeout_reg <= mem_timeout_next;
            wb_en_out_reg   <= wb_en_out_next;
            dest_out_reg    <= dest_out_next;
            wb_value_reg    <= wb_value_next;
        end
    end

    assign WB_EN_Out   = wb_en_out_reg;
    assign Dest_Out    = dest_out_reg;
    assign WB_Value    = wb_value_reg;
    assign pend_valid  = waiting;
    assign pend_dest   = lat_dest_reg;
    assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_wb_stage_ext.sv
module tb_wb_stage_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        WB_EN_In;
    logic [3:0]  Dest_In;
    logic [1:0]  wb_sel;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [31:0] ALU_Res;
    logic [31:0] Link_Val;
    logic        mem_rsp_valid;
    logic [31:0] Mem_Data;
    logic        WB_EN_Out;
    logic [3:0]  Dest_Out;
    logic [31:0] WB_Value;
    logic        pend_valid;
    logic [3:0]  pend_dest;
    logic        mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage_ext #(
        .DATA_W      (32),
        .REG_W       (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .WB_EN_In      (WB_EN_In),
        .Dest_In       (Dest_In),
        .wb_sel        (wb_sel),
        .ld_size       (ld_size),
        .ld_signed     (ld_signed),
        .ALU_Res       (ALU_Res),
        .Link_Val      (Link_Val),
        .mem_rsp_valid (mem_rsp_valid),
        .Mem_Data      (Mem_Data),
        .WB_EN_Out     (WB_EN_Out),
        .Dest_Out      (Dest_Out),
        .WB_Value      (WB_Value),
        .pend_valid    (pend_valid),
        .pend_dest     (pend_dest),
        .mem_timeout   (mem_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic en, input logic [3:0] d,
                         input logic [1:0] sel, input logic [1:0] sz, input logic sg,
                         input logic [31:0] alu, input logic [31:0] lnk,
                         input logic rsp, input logic [31:0] md);
        in_valid      = v;
        WB_EN_In      = en;
        Dest_In       = d;
        wb_sel        = sel;
        ld_size       = sz;
        ld_signed     = sg;
        ALU_Res       = alu;
        Link_Val      = lnk;
        mem_rsp_valid = rsp;
        Mem_Data      = md;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        idle();
        #2;
        chk("rst_wb_en",    WB_EN_Out,   0);
        chk("rst_dest",     Dest_Out,    0);
        chk("rst_value",    WB_Value,    0);
        chk("rst_pend",     pend_valid,  0);
        chk("rst_timeout",  mem_timeout, 0);
        chk("rst_in_ready", in_ready,    1);
        tick();
        tick();
        rst = 1'b1;
        $display("reset released");

        // ALU op, 1-cycle latency, strobe is a single pulse
        drive(1, 1, 4'd3, 2'd0, 2'd0, 1'b0, 32'h1234, 32'h0, 0, 32'h0);
        tick();
        idle();
        chk("alu_wb_en", WB_EN_Out, 1);
        chk("alu_dest",  Dest_Out,  3);
        chk("alu_value", WB_Value,  32'h1234);
        $display("ALU dest=3 value=%08h", WB_Value);
        tick();
        chk("alu_pulse_end", WB_EN_Out, 0);
        chk("alu_dest_hold", Dest_Out,  3);
        chk("alu_val_hold",  WB_Value,  32'h1234);

        // LINK select
        drive(1, 1, 4'd14, 2'd2, 2'd2, 1'b1, 32'h55, 32'hCAFE_0004, 0, 32'h0);
        tick();
        chk("link_value", WB_Value, 32'hCAFE_0004);
        chk("link_dest",  Dest_Out, 14);
        $display("LINK dest=14 value=%08h", WB_Value);

        // Reserved wb_sel behaves as ALU
        drive(1, 1, 4'd1, 2'd3, 2'd0, 1'b0, 32'hDEAD, 32'h9999, 0, 32'h0);
        tick();
        chk("rsvd_sel_value", WB_Value, 32'hDEAD);
        $display("reserved sel value=%08h", WB_Value);

        // Signed byte load at addr ..2, same-cycle response
        drive(1, 1, 4'd5, 2'd1, 2'd2, 1'b1, 32'h0000_1002, 32'h0, 1, 32'h0080_FF00);
        tick();
        chk("ldb_s_value", WB_Value, 32'hFFFF_FF80);
        chk("ldb_s_wb_en", WB_EN_Out, 1);
        $display("LDRSB value=%08h", WB_Value);

        // Unsigned half at addr 2
        drive(1, 1, 4'd6, 2'd1, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 1, 32'h0080_FF00);
        tick();
        chk("ldh_u_value", WB_Value, 32'h0000_0080);
        $display("LDRH value=%08h", WB_Value);

        // Signed half at addr 3: bit 0 ignored, upper lane selected
        drive(1, 1, 4'd6, 2'd1, 2'd1, 1'b1, 32'h0000_0003, 32'h0, 1, 32'h8001_0000);
        tick();
        chk("ldh_s_odd_value", WB_Value, 32'hFFFF_8001);
        $display("LDRSH odd value=%08h", WB_Value);

        // Unsigned byte at addr 1
        drive(1, 1, 4'd6, 2'd1, 2'd2, 1'b0, 32'h0000_0001, 32'h0, 1, 32'h0000_F100);
        tick();
        chk("ldb_u_value", WB_Value, 32'h0000_00F1);
        $display("LDRB value=%08h", WB_Value);

        // Reserved size behaves as word
        drive(1, 1, 4'd6, 2'd1, 2'd3, 1'b1, 32'h0000_0003, 32'h0, 1, 32'h89AB_CDEF);
        tick();
        chk("ld_rsvd_size", WB_Value, 32'h89AB_CDEF);
        $display("LDR rsvd size value=%08h", WB_Value);

        // Commit with WB_EN_In=0: no strobe, address still updates
        drive(1, 0, 4'd9, 2'd0, 2'd0, 1'b0, 32'h4321, 32'h0, 0, 32'h0);
        tick();
        chk("noen_wb_en", WB_EN_Out, 0);
        chk("noen_dest",  Dest_Out,  9);
        $display("no-enable commit dest=%0d", Dest_Out);

        // Load with response 3 cycles late; next ALU instr held on in_valid
        drive(1, 1, 4'd7, 2'd1, 2'd2, 1'b0, 32'h0000_0003, 32'h0, 0, 32'h1111_1111);
        tick();
        drive(1, 1, 4'd8, 2'd0, 2'd0, 1'b0, 32'h77, 32'h0, 0, 32'h2222_2222);
        for (int i = 1; i <= 3; i++) begin
            chk("late_in_ready", in_ready, 0);
            chk("late_pend",     pend_valid, 1);
            chk("late_pend_dst", pend_dest, 7);
            chk("late_wb_en",    WB_EN_Out, 0);
            $display("late load wait cycle %0d", i);
            if (i == 3) begin
                mem_rsp_valid = 1'b1;
                Mem_Data      = 32'hAB00_0000;
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        chk("late_commit_en",  WB_EN_Out, 1);
        chk("late_commit_dst", Dest_Out,  7);
        chk("late_commit_val", WB_Value,  32'h0000_00AB);
        chk("late_pend_clr",   pend_valid, 0);
        chk("late_ready_back", in_ready,  1);
        $display("late load commit value=%08h", WB_Value);
        tick();
        idle();
        chk("held_alu_en",  WB_EN_Out, 1);
        chk("held_alu_dst", Dest_Out,  8);
        chk("held_alu_val", WB_Value,  32'h77);
        $display("held ALU commit value=%08h", WB_Value);

        // Load with no response: timeout after 15 wait cycles
        drive(1, 1, 4'd10, 2'd1, 2'd0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        idle();
        for (int i = 2; i <= 15; i++) tick();
        chk("to_pend_15",    pend_valid,  1);
        chk("to_flag_early", mem_timeout, 0);
        tick();
        chk("to_pend_clr", pend_valid,  0);
        chk("to_flag",     mem_timeout, 1);
        chk("to_ready",    in_ready,    1);
        chk("to_wb_en",    WB_EN_Out,   0);
        chk("to_dest_hold", Dest_Out,   8);
        $display("timeout flag=%0d", mem_timeout);
        tick();
        chk("to_sticky", mem_timeout, 1);

        // Flush during WAIT_MEM, then response arrives
        drive(1, 1, 4'd11, 2'd1, 2'd0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        idle();
        chk("fl_pend", pend_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_pend_clr", pend_valid, 0);
        chk("fl_wb_en",    WB_EN_Out, 0);
        mem_rsp_valid = 1'b1;
        Mem_Data      = 32'h1234_5678;
        tick();
        idle();
        chk("fl_rsp_ign_en",  WB_EN_Out, 0);
        chk("fl_rsp_ign_val", WB_Value,  32'h77);
        chk("fl_timeout_kept", mem_timeout, 1);
        $display("flush in WAIT_MEM, rsp ignored");

        // Flush with a same-cycle ALU accept: dropped
        drive(1, 1, 4'd12, 2'd0, 2'd0, 1'b0, 32'h5A5A, 32'h0, 0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("fl_acc_en",  WB_EN_Out, 0);
        chk("fl_acc_dst", Dest_Out,  8);
        $display("flush drops same-cycle accept");

        // Asynchronous reset in the middle of WAIT_MEM
        drive(1, 1, 4'd13, 2'd1, 2'd0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        idle();
        chk("ar_pend", pend_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_wb_en",   WB_EN_Out,   0);
        chk("ar_dest",    Dest_Out,    0);
        chk("ar_value",   WB_Value,    0);
        chk("ar_pend",    pend_valid,  0);
        chk("ar_timeout", mem_timeout, 0);
        chk("ar_ready",   in_ready,    1);
        $display("async reset mid WAIT_MEM");
        tick();
        #2;
        rst = 1'b1;
        drive(1, 1, 4'd2, 2'd0, 2'd0, 1'b0, 32'hBEEF, 32'h0, 0, 32'h0);
        tick();
        idle();
        chk("post_rst_en",  WB_EN_Out, 1);
        chk("post_rst_dst", Dest_Out,  2);
        chk("post_rst_val", WB_Value,  32'hBEEF);
        $display("post-reset ALU value=%08h", WB_Value);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
